// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared types and constants for the arbiter-PUF challenge sequencer
//
// Purpose: FSM state encoding, LFSR feedback mask and reset seed, race-launch
// encodings and the one-step LFSR helper used by puf_lfsr32.
package puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_FIRE   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_REARM  = 3'd4,
    ST_COMMIT = 3'd5,
    ST_DONE   = 3'd6
  } puf_state_e;

  // Galois taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] DEF_SEED  = 32'hACE1_2468;

  localparam logic [1:0] RACE_IDLE = 2'b00;
  localparam logic [1:0] RACE_FIRE = 2'b11;

  // Shift right; fold the taps back in when a 1 falls out of the LSB.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/puf_lfsr32.sv
// rtl/puf_lfsr32.sv - 32-bit Galois LFSR producing the PUF challenge
//
// Purpose: holds the current challenge; loadable, single-steppable.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (q returns to SEED)
//   ld     in   load ld_val (a zero value is replaced by SEED)
//   ld_val in   32-bit load value
//   step   in   advance one LFSR step
//   q      out  current state
module puf_lfsr32
  import puf_pkg::*;
#(
  parameter logic [31:0] SEED = DEF_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld,
  input  logic [31:0] ld_val,
  input  logic        step,
  output logic [31:0] q
);

  logic [31:0] q_q;
  logic [31:0] q_d;

  // An all-zero state would lock the LFSR, so a zero seed falls back to SEED.
  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = (ld_val == 32'h0) ? SEED : ld_val;
    end else if (step) begin
      q_d = lfsr_next(q_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/puf_challenge_ctrl.sv
// rtl/puf_challenge_ctrl.sv - challenge/response sequencer for the shuffle32 arbiter PUF
//
// Purpose: applies an LFSR challenge to the delay chain, launches NREP races,
// majority-votes the synchronised arbiter decision and packs RESP_W voted bits
// (first bit at MSB) into a response word handed off with valid/ready.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   seed_ld, seed       load LFSR seed (IDLE only; zero -> DEFAULT_SEED)
//   start               begin one response word (IDLE only)
//   busy                high outside IDLE
//   chal                challenge to chain sel (LFSR state)
//   race                launch edge to chain din (00 idle, 11 fire)
//   arb_bit             arbiter output, asynchronous to clk
//   resp_valid/ready    response handshake
//   resp_data           voted response word
module puf_challenge_ctrl
  import puf_pkg::*;
#(
  parameter int          CHAL_W       = 32,
  parameter int          RESP_W       = 32,
  parameter int          NREP         = 3,
  parameter int          SETTLE       = 4,
  parameter logic [31:0] DEFAULT_SEED = DEF_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_ld,
  input  logic [CHAL_W-1:0] seed,
  input  logic              start,
  output logic              busy,
  output logic [CHAL_W-1:0] chal,
  output logic [1:0]        race,
  input  logic              arb_bit,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [RESP_W-1:0] resp_data
);

  localparam int BIT_W = $clog2(RESP_W);

  // 9 bits so the FIRE window (SETTLE+2) still fits at SETTLE=255.
  localparam logic [8:0]       SETTLE_LAST = 9'(SETTLE - 1);
  localparam logic [8:0]       FIRE_LAST   = 9'(SETTLE + 1);
  localparam logic [3:0]       REP_N       = 4'(NREP);
  localparam logic [3:0]       VOTE_HALF   = 4'(NREP / 2);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(RESP_W - 1);

  puf_state_e        state_q, state_d;
  logic [8:0]        wait_q, wait_d;
  logic [3:0]        rep_q, rep_d;
  logic [3:0]        ones_q, ones_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [RESP_W-1:0] shift_q, shift_d;
  logic              arb_meta_q, arb_s_q;
  logic              lfsr_ld, lfsr_step;
  logic              vote;
  logic [31:0]       lfsr_q;

  puf_lfsr32 #(
    .SEED(DEFAULT_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (lfsr_ld),
    .ld_val(seed),
    .step  (lfsr_step),
    .q     (lfsr_q)
  );

  assign vote = (ones_q > VOTE_HALF);

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    rep_d     = rep_q;
    ones_d    = ones_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    lfsr_ld   = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A seed load in the same cycle as start wins; start is dropped.
        if (seed_ld) begin
          lfsr_ld = 1'b1;
        end else if (start) begin
          wait_d  = '0;
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (wait_q == SETTLE_LAST) begin
          wait_d  = '0;
          state_d = ST_FIRE;
        end else begin
          wait_d = wait_q + 9'd1;
        end
      end
      ST_FIRE: begin
        // Extra two cycles cover the arbiter synchroniser latency.
        if (wait_q == FIRE_LAST) begin
          wait_d  = '0;
          state_d = ST_SAMPLE;
        end else begin
          wait_d = wait_q + 9'd1;
        end
      end
      ST_SAMPLE: begin
        ones_d  = ones_q + {3'b000, arb_s_q};
        rep_d   = rep_q + 4'd1;
        wait_d  = '0;
        state_d = ST_REARM;
      end
      ST_REARM: begin
        if (wait_q == SETTLE_LAST) begin
          wait_d  = '0;
          state_d = (rep_q < REP_N) ? ST_FIRE : ST_COMMIT;
        end else begin
          wait_d = wait_q + 9'd1;
        end
      end
      ST_COMMIT: begin
        shift_d   = {shift_q[RESP_W-2:0], vote};
        lfsr_step = 1'b1;
        ones_d    = '0;
        rep_d     = '0;
        wait_d    = '0;
        if (bit_q == BIT_LAST) begin
          state_d = ST_DONE;
        end else begin
          bit_d   = bit_q + 1'b1;
          state_d = ST_APPLY;
        end
      end
      ST_DONE: begin
        if (resp_ready) begin
          bit_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wait_q     <= '0;
      rep_q      <= '0;
      ones_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      arb_meta_q <= 1'b0;
      arb_s_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      rep_q      <= rep_d;
      ones_q     <= ones_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      arb_meta_q <= arb_bit;
      arb_s_q    <= arb_meta_q;
    end
  end

  // All outputs decode straight from registered state, so race cannot glitch
  // to 11 outside FIRE and chal only moves on the LFSR register edge.
  assign busy       = (state_q != ST_IDLE);
  assign race       = (state_q == ST_FIRE) ? RACE_FIRE : RACE_IDLE;
  assign resp_valid = (state_q == ST_DONE);
  assign resp_data  = shift_q;
  assign chal       = lfsr_q;

endmodule
